fft64_frame_feeder: RTL



---
 rtl/fft64_feed_pkg.sv | 15 +
 rtl/fft64_frame_feeder_if.sv | 17 +
 rtl/fft64_feed_bank.sv | 35 +++
 rtl/fft64_frame_feeder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fft64_feed_pkg.sv
// Shared definitions for the 64-point FFT frame feeder: sample width and
// frame length defaults, the read-side FSM state type and index width.
package fft64_feed_pkg;

  localparam int FEED_DATA_W    = 24;
  localparam int FEED_FRAME_LEN = 64;
  localparam int FEED_IDX_W     = $clog2(FEED_FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } feed_state_e;

endpackage

// File: rtl/fft64_frame_feeder_if.sv
// Upstream ready/valid sample stream into the frame feeder.
// master = sample source, slave = feeder.
interface fft64_frame_feeder_if
  import fft64_feed_pkg::*;
#(
  parameter int DATA_W = FEED_DATA_W
);

  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_real;
  logic signed [DATA_W-1:0] s_imag;

  modport master (output s_valid, output s_real, output s_imag, input s_ready);
  modport slave  (input s_valid, input s_real, input s_imag, output s_ready);

endinterface

// File: rtl/fft64_feed_bank.sv
// Ping-pong sample store: 2 x FRAME_LEN words of {real, imag}.
// Synchronous write port; registered read port that returns zero on
// cycles without a read so the core input is clean between bursts.
module fft64_feed_bank
  import fft64_feed_pkg::*;
#(
  parameter int DATA_W    = FEED_DATA_W,
  parameter int FRAME_LEN = FEED_FRAME_LEN,
  localparam int ADDR_W   = $clog2(2 * FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [2*DATA_W-1:0]   rd_data
);

  logic [2*DATA_W-1:0] mem [2*FRAME_LEN];

  // Sample storage, written one word per accepted (or padded) sample
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; cleared by reset so the core sees zeros at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end

endmodule

// File: rtl/fft64_frame_feeder.sv
// Transmit-side framer for fft64_core. Collects upstream samples into a
// ping-pong buffer and plays each complete frame out as an unbroken burst
// of FRAME_LEN cycles. Optional macro FFT_FEED_FLUSH_EN adds a flush port
// that zero-pads and releases a partially filled frame.
module fft64_frame_feeder
  import fft64_feed_pkg::*;
#(
  parameter int DATA_W     = FEED_DATA_W,
  parameter int FRAME_LEN  = FEED_FRAME_LEN,
  parameter int GAP_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  fft64_frame_feeder_if.slave      s,
`ifdef FFT_FEED_FLUSH_EN
  input  logic                     flush,
`endif
  output logic                     din_valid,
  output logic signed [DATA_W-1:0] din_real,
  output logic signed [DATA_W-1:0] din_imag,
  output logic                     frame_start,
  output logic [15:0]              frame_cnt
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [1:0]          full;
  logic                wr_bank;
  logic                rd_bank;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [GAP_W-1:0]    gap_cnt;
  feed_state_e         state;
  feed_state_e         state_nxt;
  logic                padding;
  logic                xfer;
  logic                wr_en;
  logic                wr_last;
  logic                rd_en;
  logic                rd_last;
  logic [2*DATA_W-1:0] wr_data;
  logic [2*DATA_W-1:0] rd_data;

  assign s.s_ready = !full[wr_bank] && !padding && !rst;
  assign xfer      = s.s_valid && s.s_ready;
  assign wr_en     = xfer || padding;
  assign wr_last   = wr_en && (wr_idx == LAST_IDX);
  assign wr_data   = padding ? '0 : {s.s_real, s.s_imag};
  assign rd_en     = (state == BURST);
  assign rd_last   = rd_en && (rd_idx == LAST_IDX);

  fft64_feed_bank #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_idx}),
    .rd_data (rd_data)
  );

  assign din_real = rd_data[2*DATA_W-1:DATA_W];
  assign din_imag = rd_data[DATA_W-1:0];

`ifdef FFT_FEED_FLUSH_EN
  // Flush closes a partial frame: after any same-cycle transfer, zero-pad to the end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      padding <= 1'b0;
    end else if (padding) begin
      if (wr_idx == LAST_IDX) padding <= 1'b0;
    end else if (flush && (wr_idx != '0) && !(xfer && (wr_idx == LAST_IDX))) begin
      padding <= 1'b1;
    end
  end
`else
  assign padding = 1'b0;
`endif

  // Write pointer: advance per stored word, switch banks when a frame completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (wr_en) begin
      wr_idx <= wr_idx + IDX_W'(1);
      if (wr_last) wr_bank <= ~wr_bank;
    end
  end

  // Bank-full flags: set by the writer on frame completion, cleared by the reader after playout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (wr_last) full[wr_bank] <= 1'b1;
      if (rd_last) full[rd_bank] <= 1'b0;
    end
  end

  // Read FSM next state: chain bursts directly when the other bank is already waiting
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (full[rd_bank] && (gap_cnt == '0)) state_nxt = BURST;
      end
      BURST: begin
        if (rd_last) begin
          if (GAP_CYCLES > 0)      state_nxt = GAP;
          else if (full[~rd_bank]) state_nxt = BURST;
          else                     state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt <= GAP_W'(1)) state_nxt = full[rd_bank] ? BURST : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Read pointer, bank release, burst counter and the inter-burst gap counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx    <= '0;
      rd_bank   <= 1'b0;
      frame_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      if (rd_en) rd_idx <= rd_idx + IDX_W'(1);
      if (rd_last) begin
        rd_bank   <= ~rd_bank;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (rd_last && (GAP_CYCLES > 0)) gap_cnt <= GAP_W'(GAP_CYCLES);
      else if ((state == GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // Burst qualifiers, aligned with the registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      din_valid   <= rd_en;
      frame_start <= rd_en && (rd_idx == '0);
    end
  end

endmodule
